// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H 245-sync FIFO responder.
package ft232h_pkg;

   localparam int unsigned BYTE_W = 8;

   // Bus ownership: idle, one-cycle turnaround, responder driving RX data.
   typedef enum logic [1:0] {
      StIdle,
      StRxTurn,
      StRxDrive
   } bus_state_t;

endpackage

// File: rtl/ft232h_fifo_responder_if.sv
// FT232H pin bundle plus host-side RX/TX byte streams.
// master: the FPGA/host side; slave: the chip-side responder.
interface ft232h_fifo_responder_if;

   logic                            rxf_n;
   logic                            txe_n;
   logic                            rd_n;
   logic                            wr_n;
   logic                            oe_n;
   logic                            siwu_n;
   logic [ft232h_pkg::BYTE_W-1:0]   data_in;
   logic [ft232h_pkg::BYTE_W-1:0]   data_out;
   logic                            data_oe;
   logic [ft232h_pkg::BYTE_W-1:0]   host_rx_data;
   logic                            host_rx_valid;
   logic                            host_rx_ready;
   logic [ft232h_pkg::BYTE_W-1:0]   host_tx_data;
   logic                            host_tx_valid;
   logic                            host_tx_ready;

   modport master (
      input  rxf_n, txe_n, data_out, data_oe, host_rx_ready, host_tx_data, host_tx_valid,
      output rd_n, wr_n, oe_n, siwu_n, data_in, host_rx_data, host_rx_valid, host_tx_ready
   );

   modport slave (
      output rxf_n, txe_n, data_out, data_oe, host_rx_ready, host_tx_data, host_tx_valid,
      input  rd_n, wr_n, oe_n, siwu_n, data_in, host_rx_data, host_rx_valid, host_tx_ready
   );

endinterface

// File: rtl/ft232h_resp_fifo.sv
// Synchronous first-word-fall-through byte FIFO. A full FIFO accepts a push
// on the same edge as a pop. Storage is reset so the head reads 0 after reset.
module ft232h_resp_fifo
   import ft232h_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [BYTE_W-1:0]       wdata_i,
   output logic [BYTE_W-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [$clog2(DEPTH):0]  count_next_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              do_push, do_pop;

   assign full_o       = (count_q == CntW'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign do_pop       = pop_i & ~empty_o;
   assign do_push      = push_i & (~full_o | do_pop);
   assign rdata_o      = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign count_next_o = count_d;

   // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Storage, pointers (wrap modulo DEPTH) and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ft232h_fifo_responder.sv
// Chip-side model of the FT232H 245 synchronous FIFO interface. Answers an
// FPGA-side master on the FT232H pins and bridges to host RX/TX byte streams.
// Optional feature macro FT232H_RESP_SIWU_EN: TX bytes are held back until
// TX_PKT_THRESHOLD are queued or a send-immediate (siwu_n) flush is pending.
module ft232h_fifo_responder
   import ft232h_pkg::*;
#(
   parameter int unsigned DEPTH            = 16,
   parameter int unsigned TX_PKT_THRESHOLD = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   ft232h_fifo_responder_if.slave bus_if,
   output logic                   proto_err_o
);

   localparam int unsigned     CntW    = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   bus_state_t        state_q;
   logic              data_oe_q, proto_err_q;
   logic              rxf_n_q, txe_n_q, host_rx_ready_q;
   logic              rx_push, rx_pop, tx_push, tx_pop, tx_valid;
   logic [BYTE_W-1:0] rx_head, tx_head;
   logic [CntW-1:0]   rx_cnt, rx_cnt_next, tx_cnt, tx_cnt_next;
   logic              rx_full, rx_empty, tx_full, tx_empty;

   assign rx_push = bus_if.host_rx_valid & host_rx_ready_q;
   assign rx_pop  = ~bus_if.rd_n & ~bus_if.oe_n & ~rxf_n_q & (state_q == StRxDrive);
   // Writes are refused while the responder owns the bus.
   assign tx_push = ~bus_if.wr_n & ~txe_n_q & (state_q != StRxDrive) & ~data_oe_q;
   assign tx_pop  = tx_valid & bus_if.host_tx_ready;

   ft232h_resp_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (rx_push),
      .pop_i        (rx_pop),
      .wdata_i      (bus_if.host_rx_data),
      .rdata_o      (rx_head),
      .count_o      (rx_cnt),
      .count_next_o (rx_cnt_next),
      .full_o       (rx_full),
      .empty_o      (rx_empty)
   );

   ft232h_resp_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (tx_push),
      .pop_i        (tx_pop),
      .wdata_i      (bus_if.data_in),
      .rdata_o      (tx_head),
      .count_o      (tx_cnt),
      .count_next_o (tx_cnt_next),
      .full_o       (tx_full),
      .empty_o      (tx_empty)
   );

`ifdef FT232H_RESP_SIWU_EN
   localparam logic [CntW-1:0] ThrCnt = CntW'(TX_PKT_THRESHOLD);
   logic flush_q;

   // siwu_n arms a flush that holds until the TX FIFO drains.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_q <= 1'b0;
      end else if (!bus_if.siwu_n) begin
         flush_q <= 1'b1;
      end else if (tx_cnt_next == '0) begin
         flush_q <= 1'b0;
      end
   end

   assign tx_valid = ~tx_empty & ((tx_cnt >= ThrCnt) | flush_q);

   logic unused_sig;
   assign unused_sig = ^{rx_cnt, rx_full, rx_empty, tx_full};
`else
   assign tx_valid = ~tx_empty;

   logic unused_sig;
   assign unused_sig = ^{rx_cnt, rx_full, rx_empty, tx_full, tx_cnt, bus_if.siwu_n,
                         (TX_PKT_THRESHOLD != 0)};
`endif

   // Status flags reflect FIFO occupancy after the current edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxf_n_q         <= 1'b1;
         txe_n_q         <= 1'b1;
         host_rx_ready_q <= 1'b0;
      end else begin
         rxf_n_q         <= (rx_cnt_next == '0);
         txe_n_q         <= (tx_cnt_next == FullCnt);
         host_rx_ready_q <= (rx_cnt_next != FullCnt);
      end
   end

   // Bus ownership FSM with registered drive enable and sticky error flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         data_oe_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         if ((!bus_if.rd_n && state_q != StRxDrive) || (!bus_if.wr_n && data_oe_q)) begin
            proto_err_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (!bus_if.oe_n) begin
                  state_q   <= StRxTurn;
                  data_oe_q <= 1'b1;
               end
            end
            StRxTurn: begin
               if (bus_if.oe_n) begin
                  state_q   <= StIdle;
                  data_oe_q <= 1'b0;
               end else begin
                  state_q   <= StRxDrive;
               end
            end
            StRxDrive: begin
               if (bus_if.oe_n) begin
                  state_q   <= StIdle;
                  data_oe_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               data_oe_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_if.rxf_n         = rxf_n_q;
   assign bus_if.txe_n         = txe_n_q;
   assign bus_if.data_out      = rx_head;
   assign bus_if.data_oe       = data_oe_q;
   assign bus_if.host_rx_ready = host_rx_ready_q;
   assign bus_if.host_tx_data  = tx_head;
   assign bus_if.host_tx_valid = tx_valid;
   assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_ft232h_fifo_responder.sv
// Bench for ft232h_fifo_responder: directed scenarios then random traffic,
// checked by a queue-based reference model and scoreboard on the falling edge.
module tb_ft232h_fifo_responder;

   localparam int DEPTH = 16;
   localparam int THR   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic proto_err;
   int   total = 0;
   int   bad   = 0;

   ft232h_fifo_responder_if bus_if ();

   ft232h_fifo_responder #(
      .DEPTH            (DEPTH),
      .TX_PKT_THRESHOLD (THR)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus_if      (bus_if),
      .proto_err_o (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queues plus a few abstract flags.
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         after_reset;
   int         oe_run;     // consecutive edges that saw oe_n low (saturating at 2)
   bit         perr;
   bit         flush;
   bit         exp_ready, exp_txe_n, exp_valid, in_drive, rx_pop, tx_pop, rx_push, tx_push;

   always @(negedge clk) begin
      if (rst) begin
         rxq.delete();
         txq.delete();
         after_reset = 1'b1;
         oe_run      = 0;
         perr        = 1'b0;
         flush       = 1'b0;
      end else begin
         exp_ready = !after_reset && rxq.size() != DEPTH;
         exp_txe_n = after_reset || txq.size() == DEPTH;
`ifdef FT232H_RESP_SIWU_EN
         exp_valid = txq.size() != 0 && (txq.size() >= THR || flush);
`else
         exp_valid = txq.size() != 0;
`endif
         chk("rxf_n", bus_if.rxf_n, rxq.size() == 0);
         chk("txe_n", bus_if.txe_n, exp_txe_n);
         chk("host_rx_ready", bus_if.host_rx_ready, exp_ready);
         chk("host_tx_valid", bus_if.host_tx_valid, exp_valid);
         chk("data_oe", bus_if.data_oe, oe_run >= 1);
         chk("proto_err", proto_err, perr);

         // What the coming edge does, decided from the current inputs.
         in_drive = oe_run >= 2;
         rx_pop   = in_drive && !bus_if.oe_n && !bus_if.rd_n && rxq.size() != 0;
         tx_pop   = exp_valid && bus_if.host_tx_ready;
         rx_push  = bus_if.host_rx_valid && exp_ready;
         tx_push  = !bus_if.wr_n && oe_run == 0 && !exp_txe_n;
         if (rx_pop) begin
            chk("rx_byte", bus_if.data_out, rxq[0]);
            void'(rxq.pop_front());
         end
         if (tx_pop) begin
            chk("tx_byte", bus_if.host_tx_data, txq[0]);
            void'(txq.pop_front());
         end
         if (rx_push) rxq.push_back(bus_if.host_rx_data);
         if (tx_push) txq.push_back(bus_if.data_in);
         if ((!bus_if.rd_n && !in_drive) || (!bus_if.wr_n && oe_run >= 1)) perr = 1'b1;
         if (!bus_if.siwu_n) flush = 1'b1;
         else if (txq.size() == 0) flush = 1'b0;
         oe_run      = bus_if.oe_n ? 0 : ((oe_run < 2) ? oe_run + 1 : 2);
         after_reset = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus_if.rd_n          = 1'b1;
      bus_if.wr_n          = 1'b1;
      bus_if.oe_n          = 1'b1;
      bus_if.siwu_n        = 1'b1;
      bus_if.data_in       = 8'h00;
      bus_if.host_rx_data  = 8'h00;
      bus_if.host_rx_valid = 1'b0;
      bus_if.host_tx_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rxf_n"}, bus_if.rxf_n, 1);
      chk({tag, "_txe_n"}, bus_if.txe_n, 1);
      chk({tag, "_data_oe"}, bus_if.data_oe, 0);
      chk({tag, "_data_out"}, bus_if.data_out, 0);
      chk({tag, "_host_rx_ready"}, bus_if.host_rx_ready, 0);
      chk({tag, "_host_tx_valid"}, bus_if.host_tx_valid, 0);
      chk({tag, "_host_tx_data"}, bus_if.host_tx_data, 0);
      chk({tag, "_proto_err"}, proto_err, 0);
   endtask

   task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         bus_if.host_rx_valid = 1'($urandom_range(0, 1));
         bus_if.host_rx_data  = 8'($urandom);
         bus_if.host_tx_ready = ($urandom % 3) != 0;
         if ($urandom % 8 == 0) bus_if.oe_n = ~bus_if.oe_n;
         bus_if.rd_n    = !(bus_if.oe_n == 1'b0 && ($urandom % 2 == 1)) && ($urandom % 64 != 0);
         bus_if.wr_n    = !(bus_if.oe_n == 1'b1 && ($urandom % 2 == 1)) && ($urandom % 64 != 0);
         bus_if.data_in = 8'($urandom);
         bus_if.siwu_n  = ($urandom % 16) != 0;
         step();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();
      chk("first_rx_ready", bus_if.host_rx_ready, 1);
      chk("first_txe_n", bus_if.txe_n, 0);

      // Host pushes two bytes, FPGA reads them after the turnaround.
      bus_if.host_rx_valid = 1'b1;
      bus_if.host_rx_data  = 8'h45;
      step();
      bus_if.host_rx_data  = 8'h46;
      step();
      bus_if.host_rx_valid = 1'b0;
      bus_if.oe_n          = 1'b0;
      step();
      chk("oe_turnaround", bus_if.data_oe, 1);
      step();
      chk("rx_head_45", bus_if.data_out, 8'h45);
      bus_if.rd_n = 1'b0;
      step();
      step();
      bus_if.rd_n = 1'b1;
      bus_if.oe_n = 1'b1;
      step();
      chk("rx_drained", bus_if.rxf_n, 1);

      // Single FPGA write forwarded to the host.
      bus_if.host_tx_ready = 1'b1;
      bus_if.wr_n          = 1'b0;
      bus_if.data_in       = 8'h69;
      step();
      bus_if.wr_n = 1'b1;
`ifndef FT232H_RESP_SIWU_EN
      chk("tx_valid_69", bus_if.host_tx_valid, 1);
      chk("tx_data_69", bus_if.host_tx_data, 8'h69);
`endif
      step();
      step();

      // Fill TX completely; the 17th write must be dropped.
      bus_if.host_tx_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         bus_if.wr_n    = 1'b0;
         bus_if.data_in = 8'(i);
         step();
      end
      bus_if.wr_n = 1'b1;
      chk("tx_full_txe_n", bus_if.txe_n, 1);
      bus_if.siwu_n = 1'b0;
      bus_if.host_tx_ready = 1'b1;
      step();
      bus_if.siwu_n = 1'b1;
      repeat (DEPTH + 2) step();
      chk("tx_drained", bus_if.host_tx_valid, 0);

      // Contention during RX_DRIVE, then a read strobe in IDLE.
      bus_if.host_rx_valid = 1'b1;
      bus_if.host_rx_data  = 8'h77;
      step();
      bus_if.host_rx_valid = 1'b0;
      bus_if.oe_n          = 1'b0;
      step();
      step();
      bus_if.wr_n    = 1'b0;
      bus_if.data_in = 8'hAA;
      step();
      bus_if.wr_n = 1'b1;
      bus_if.oe_n = 1'b1;
      step();
      chk("contention_err", proto_err, 1);
      chk("contention_no_push", bus_if.host_tx_valid, 0);
      bus_if.rd_n = 1'b0;
      step();
      bus_if.rd_n = 1'b1;
      step();
      chk("idle_rd_no_pop", bus_if.rxf_n, 0);
      chk("err_sticky", proto_err, 1);

      // Asynchronous reset in the middle of a read burst.
      bus_if.host_rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus_if.host_rx_data = 8'(8'h30 + i);
         step();
      end
      bus_if.host_rx_valid = 1'b0;
      bus_if.oe_n          = 1'b0;
      step();
      step();
      bus_if.rd_n = 1'b0;
      step();
      step();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midburst");
      set_idle();
      step();
      step();
      rst = 1'b0;
      step();

`ifdef FT232H_RESP_SIWU_EN
      // Below-threshold bytes wait for a send-immediate flush.
      bus_if.host_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.wr_n    = 1'b0;
         bus_if.data_in = 8'(8'hC0 + i);
         step();
      end
      bus_if.wr_n = 1'b1;
      repeat (3) step();
      chk("siwu_held", bus_if.host_tx_valid, 0);
      bus_if.siwu_n = 1'b0;
      step();
      bus_if.siwu_n = 1'b1;
      repeat (6) step();
      chk("siwu_flushed", bus_if.host_tx_valid, 0);
      set_idle();
`endif

      random_phase(700);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outputs("rand_reset");
      step();
      rst = 1'b0;
      step();
      random_phase(700);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ft232h_fifo_responder.md
Name: ft232h_fifo_responder

Overview:
- Synthesizable chip-side model of the FT232H 245 synchronous FIFO interface: it responds to the FPGA-side ft232h master on the same pins (rxf_n/txe_n/rd_n/wr_n/oe_n/siwu_n/data).
- Host side exposes two valid/ready byte streams. RX stream: host to FPGA. TX stream: FPGA to host.
- Used for on-chip loopback, hardware-in-loop tests and simulation in place of the physical chip.

Parameters:
- DEPTH, 16: entries per internal FIFO; power of 2, >= 4.
- TX_PKT_THRESHOLD, 8: TX occupancy at which bytes are released to the host. Used only with the optional feature.

Ports:
- clk  in  1  single clock; ft232h bus and host streams are synchronous to it
- reset  in  1  asynchronous, active-high reset
- rxf_n  out  1  low = RX data available to FPGA
- txe_n  out  1  low = TX space available for FPGA writes
- rd_n  in  1  FPGA read strobe, active low
- wr_n  in  1  FPGA write strobe, active low
- oe_n  in  1  FPGA output-enable request, active low
- siwu_n  in  1  send-immediate, active low
- data_in  in  8  bus byte driven by FPGA
- data_out  out  8  bus byte driven by responder
- data_oe  out  1  responder drives bus; top-level wraps into inout
- host_rx_data  in  8  host byte toward FPGA
- host_rx_valid  in  1
- host_rx_ready  out  1  = RX FIFO not full
- host_tx_data  out  8  byte written by FPGA
- host_tx_valid  out  1
- host_tx_ready  in  1
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: rxf_n=1, txe_n=1, data_oe=0, data_out=0, host_rx_ready=0, host_tx_valid=0, proto_err=0. Both FIFOs empty. State IDLE.
- First cycle after reset deassertion: host_rx_ready=1 and txe_n=0 (outputs registered).
- Both FIFOs are first-word-fall-through. data_out = RX head; host_tx_data = TX head.
- Host RX push: on posedge when host_rx_valid & host_rx_ready.
- Host TX pop: on posedge when host_tx_valid & host_tx_ready.
- rxf_n: registered; rxf_n = (RX count after this edge == 0).
- txe_n: registered; txe_n = (TX count after this edge == DEPTH).
- FPGA read pop: on posedge when rd_n=0, oe_n=0, rxf_n=0 and state=RX_DRIVE. Consecutive rd_n-low cycles stream one byte per clock.
- FPGA write push: on posedge when wr_n=0, txe_n=0 and state != RX_DRIVE. data_in is captured.
- Bus FSM:
  - IDLE: oe_n=0 & rxf_n=0 -> RX_TURN. oe_n=0 & rxf_n=1 -> RX_TURN (bus driven with stale head; no pop possible).
  - RX_TURN: data_oe=1 registered (one-cycle turnaround); -> RX_DRIVE. oe_n=1 -> IDLE.
  - RX_DRIVE: data_oe=1; pops per rules above; oe_n=1 -> IDLE, and data_oe drops the same edge.
  - rd_n=0 in IDLE or RX_TURN: no pop; proto_err set.
- Contention: wr_n=0 while data_oe=1 -> write ignored, proto_err set.
- Counters are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Same-edge push and pop on one FIFO: count unchanged; a full FIFO accepts the push. rxf_n/txe_n hold.
- RX FIFO empties mid-burst: rxf_n=1 from the next cycle; further rd_n ignored, no error.
- reset mid-burst: everything returns to reset values immediately. Data is lost.
- proto_err clears only on reset.

Optional Feature:
- Macro FT232H_RESP_SIWU_EN.
- Defined: host_tx_valid is gated. Bytes are offered only while TX count >= TX_PKT_THRESHOLD, or while a flush is pending.
  - siwu_n low on a posedge arms the flush.
  - Flush clears when the TX FIFO becomes empty.
- Undefined: host_tx_valid = TX not empty; siwu_n ignored; TX_PKT_THRESHOLD unused.

Decomposition:
- Package ft232h_pkg:
  - bus_state_t enum (IDLE, RX_TURN, RX_DRIVE)
  - BYTE_W=8 constant
- Sub-module ft232h_resp_fifo: sync FWFT FIFO, parameter DEPTH; ports push/pop/data/count/full/empty. Instantiated twice (RX, TX).

Test Plan:
- Reset, then host pushes 0x45, 0x46. FPGA drives oe_n=0, then rd_n=0 for 2 cycles. Expect: data_oe=1 one cycle after oe_n; bytes 0x45, 0x46 in order; rxf_n=1 afterwards.
- FPGA writes 0x69 with wr_n=0 one cycle, host_tx_ready=1 → host_tx_data=0x69, host_tx_valid=1 next cycle.
- FPGA writes DEPTH=16 bytes with host_tx_ready=0 → txe_n=1 after 16th; 17th write dropped; drain yields 0..15 in order.
- wr_n=0 during RX_DRIVE → no TX push, proto_err=1; rd_n=0 in IDLE → no pop, proto_err stays 1 until reset.
- reset asserted mid-read burst of 5 bytes → all outputs at reset values that cycle; RX empty.
- FT232H_RESP_SIWU_EN, threshold 8: write 3 bytes → host_tx_valid=0. Pulse siwu_n → 3 bytes delivered, then host_tx_valid=0.
